mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage, beside the ALU. Takes the
//  same forwarded operands (A = rs, B = rt) and owns the HI/LO registers for
//  mult/multu/div/divu/mthi/mtlo. Busy is exposed for the hazard unit, which stalls
//  dependent instructions (mfhi/mflo and any new md op) while busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (1..15)
//  DIV_CYCLES   10  busy cycles for div/divu (1..15)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   synchronous, active-low (0 = reset on next rising edge)
//  start   in   1   one-cycle request; op/A/B are sampled on the same edge
//  md_op   in   3   operation code (see package)
//  A       in   32  operand rs (forwarded)
//  B       in   32  operand rt (forwarded)
//  busy    out  1   operation in flight; HI/LO not yet final
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  - Reset (reset==0 at edge): hi=0, lo=0, busy=0, counter=0. Reset mid-operation
//    aborts it; the pending result is discarded.
//  - Accept: start==1 && busy==0 at an edge. start while busy==1 is ignored
//    (hazard unit guarantees it never happens; the unit must not corrupt state).
//  - MTHI/MTLO: hi<=A / lo<=A at the accept edge; busy stays 0; zero latency.
//  - MULT/MULTU/DIV/DIVU: at accept edge latch 64-bit pending result, busy<=1,
//    counter<=MULT_CYCLES or DIV_CYCLES. Each busy edge decrements counter; at the
//    edge where counter==1: {hi,lo}<=pending, busy<=0. busy is therefore high
//    for exactly N cycles; new hi/lo are visible in the cycle busy first reads 0.
//  - MD_NONE or unused codes with start==1: no effect.
//  - MULT: {hi,lo} = signed(A)*signed(B), 64-bit. MULTU: unsigned product.
//  - DIV: lo = quotient truncated toward zero; hi = remainder with sign of A.
//    DIVU: unsigned quotient/remainder.
//  - B==0 on DIV/DIVU: operation still runs DIV_CYCLES with busy; hi/lo
//    unchanged at completion.
//  - DIV 0x80000000 / 0xFFFFFFFF (overflow): lo=0x80000000, hi=0.
//  - hi/lo change only at reset, MTHI/MTLO accept, or completion edge.
// STRUCTURE
//  - Shared package md_pkg: MD_NONE=3'd0, MD_MULT=3'd1, MD_MULTU=3'd2,
//    MD_DIV=3'd3, MD_DIVU=3'd4, MD_MTHI=3'd5, MD_MTLO=3'd6; also imported by
//    the controller and hazard unit.
//  - One sub-module md_compute: combinational (op, A, B) -> {hi,lo} 64-bit
//    pending result incl. div-by-zero keep-flag; top holds counter/busy/HI/LO.
//  - Counter 4 bits; parameters > 15 are illegal.
// TESTING
//  1 reset=0 two cycles -> hi=0, lo=0, busy=0; reset=1, idle 3 cycles -> unchanged.
//  2 MULT A=0xFFFFFFFE(-2) B=3 -> busy=1 for exactly 5 cycles, then
//    hi=0xFFFFFFFF lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002 lo=0xFFFFFFFA.
//  3 DIV A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIVU A=7 B=2 -> lo=3 hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 MTHI A=0x12345678 -> hi=0x12345678 next cycle, busy never 1; MTLO A=0xA5 ->
//    lo=0xA5. DIVU with B=0 after that -> busy 10 cycles, hi/lo unchanged.
//  5 start MULT, then start DIV with A=100 B=5 at cycle 2 of busy -> ignored;
//    only MULT result lands, busy falls after 5 cycles total.
//  6 start DIV A=100 B=7, assert reset=0 at busy cycle 4 -> next cycle busy=0,
//    hi=0, lo=0; no later write of 14/2 occurs.

Source files
------------

// File: rtl/md_pkg.sv
// =============================================================================
// md_pkg : operation codes shared by the multiply/divide unit, controller and
//          hazard unit.  Revision 1.0
// =============================================================================
`default_nettype none

package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/md_compute.sv
// =============================================================================
// md_compute : combinational {hi,lo} result for mult/multu/div/divu plus a flag
//              telling the top to keep HI/LO on a divide by zero.  Revision 1.0
// =============================================================================
`default_nettype none

module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] result,
    output logic        keep
);

    logic               b_zero;
    logic               s_ovf;
    logic [31:0]        s_div;
    logic [31:0]        u_div;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign b_zero = (B == 32'd0);
    assign s_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 on overflow gives exactly the required
    // lo=0x80000000, hi=0, and the substitution keeps the divider defined.
    assign s_div  = (b_zero || s_ovf) ? 32'd1 : B;
    assign u_div  = b_zero ? 32'd1 : B;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign quo_s  = $signed(A) / $signed(s_div);
    assign rem_s  = $signed(A) % $signed(s_div);
    assign quo_u  = A / u_div;
    assign rem_u  = A % u_div;

    always_comb begin
        result = 64'd0;
        keep   = 1'b0;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result = {rem_s, quo_s};
                keep   = b_zero;
            end
            MD_DIVU: begin
                result = {rem_u, quo_u};
                keep   = b_zero;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// =============================================================================
// mult_div_unit : multi-cycle multiply/divide unit owning HI/LO; busy drives
//                 the hazard unit's stall.  Revision 1.0
// =============================================================================
`default_nettype none

module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0]         next_result;
    logic                next_keep;
    logic [63:0]         pending;
    logic                pending_keep;
    logic [MD_CNT_W-1:0] counter;

    md_compute u_compute (
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .result (next_result),
        .keep   (next_keep)
    );

    // A new start is only examined while idle, so a stray request during an
    // operation cannot disturb the pending result or the counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi           <= 32'd0;
            lo           <= 32'd0;
            busy         <= 1'b0;
            counter      <= '0;
            pending      <= 64'd0;
            pending_keep <= 1'b0;
        end else if (busy) begin
            counter <= counter - 1'b1;
            if (counter == MD_CNT_W'(1)) begin
                busy <= 1'b0;
                if (!pending_keep) begin
                    hi <= pending[63:32];
                    lo <= pending[31:0];
                end
            end
        end else if (start) begin
            case (md_op)
                MD_MTHI: hi <= A;
                MD_MTLO: lo <= A;
                MD_MULT, MD_MULTU: begin
                    pending      <= next_result;
                    pending_keep <= 1'b0;
                    busy         <= 1'b1;
                    counter      <= MD_CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    pending      <= next_result;
                    pending_keep <= next_keep;
                    busy         <= 1'b1;
                    counter      <= MD_CNT_W'(DIV_CYCLES);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// =============================================================================
// tb_mult_div_unit : directed table-driven bench for mult_div_unit with
//                    hand-written stall-ignore and reset-abort sequences.
//                    Revision 1.0
// =============================================================================
`default_nettype none

module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue at a negedge so the request is sampled on the next posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'hDEAD_BEEF;
        B     = 32'hDEAD_BEEF;
    endtask

    // Counts busy cycles after accept; also flags any HI/LO movement while busy.
    task automatic wait_done(input string name, input logic [31:0] old_hi,
                             input logic [31:0] old_lo, output int cycles);
        bit moved = 0;
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (hi !== old_hi || lo !== old_lo) moved = 1;
        end
        chk({name, " hilo_stable_while_busy"}, 64'(moved), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] h0, l0;

        vecs.push_back('{"mult",      MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{"multu",     MD_MULTU, 32'hFFFF_FFFE, 32'd3,         5,  32'h0000_0002, 32'hFFFF_FFFA});
        vecs.push_back('{"div",       MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"divu",      MD_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3});
        vecs.push_back('{"div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000});
        vecs.push_back('{"mthi",      MD_MTHI,  32'h1234_5678, 32'd0,         0,  32'h1234_5678, 32'h8000_0000});
        vecs.push_back('{"mtlo",      MD_MTLO,  32'h0000_00A5, 32'd0,         0,  32'h1234_5678, 32'h0000_00A5});
        vecs.push_back('{"divu_by0",  MD_DIVU,  32'd99,        32'd0,         10, 32'h1234_5678, 32'h0000_00A5});
        vecs.push_back('{"mult_max",  MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001});
        vecs.push_back('{"div_nn",    MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'd3});
        vecs.push_back('{"div_pn",    MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"div_by0",   MD_DIV,   32'd5,         32'd0,         10, 32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"none",      MD_NONE,  32'd5,         32'd6,         0,  32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"unused7",   3'd7,     32'd5,         32'd6,         0,  32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"divu_big",  MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'd0});

        // Reset behaviour
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_hilo", {hi, lo}, 64'd0);

        foreach (vecs[i]) begin
            h0 = hi;
            l0 = lo;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, h0, l0, cyc);
            chk({vecs[i].name, " cycles"}, 64'(cyc), 64'(vecs[i].cycles));
            chk({vecs[i].name, " hilo"}, {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // A start during busy cycle 2 must be ignored.
        h0 = hi;
        l0 = lo;
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        start = 1'b1;
        md_op = MD_DIV;
        A     = 32'd100;
        B     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        wait_done("ignore", h0, l0, cyc);
        chk("ignore cycles", 64'(cyc + 1), 64'd5);
        chk("ignore hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        repeat (15) @(negedge clk);
        chk("ignore later_busy", 64'(busy), 64'd0);
        chk("ignore later_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

        // Reset asserted during busy cycle 4 aborts the divide.
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        chk("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort later_busy", 64'(busy), 64'd0);
        chk("abort later_hilo", {hi, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
